gray_conv_arbiter: RTL and testbench
====================================

GRAY_CONV_ARBITER -- requirements
Module: gray_conv_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters; fixed at 4 in this release.
REQ-002 Parameter W, default 4, Gray/binary code width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req  input  NREQ  per-requester conversion request, level-held until granted.
REQ-006 gray_in  input  NREQ*W  Gray codes; requester i occupies bits [i*W+W-1 : i*W].
REQ-007 gnt  output  NREQ  one-hot grant pulse, one cycle, combinational from current state and req.
REQ-008 out_valid  output  1  converted result held in output register.
REQ-009 out_ready  input  1  downstream accepts result when high with out_valid.
REQ-010 out_bin  output  W  binary result of the granted Gray code.
REQ-011 out_id  output  2  index of requester that produced out_bin.

Function
REQ-012 Two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-013 Accept slot exists when state is EMPTY, or FULL with out_ready=1 (same-cycle drain and refill).
REQ-014 With an accept slot and any req bit set, exactly one gnt bit is asserted: the first set req bit at or after rr_ptr, searching upward with wrap 3->0.
REQ-015 No accept slot, or req==0: gnt=0, rr_ptr and output register unchanged.
REQ-016 On a grant to requester k: out_bin <= bin(gray_in[k]), out_id <= k, out_valid <= 1, rr_ptr <= (k+1) mod 4, all at the same clock edge.
REQ-017 Conversion: out_bin[W-1] = g[W-1]; out_bin[i] = out_bin[i+1] XOR g[i] for i = W-2 down to 0.
REQ-018 Latency: grant cycle N -> out_valid and out_bin visible in cycle N+1; sustained throughput one result per cycle while out_ready=1.
REQ-019 FULL with out_ready=1 and no req: transition to EMPTY, out_valid <= 0.
REQ-020 FULL with out_ready=0: out_bin, out_id, out_valid held stable (no overwrite).
REQ-021 A requester that drops req before grant is skipped with no side effects; gray_in of non-granted requesters is ignored.
REQ-022 All four req high continuously with out_ready=1: grants cycle 0,1,2,3,0,... with no starvation; every requester granted within 4 accept slots.

Reset
REQ-023 While rst=1: out_valid=0, out_bin=0, out_id=0, rr_ptr=0, state EMPTY, gnt=0.
REQ-024 rst asserted mid-operation discards any held result immediately, without waiting for a clock edge; first grant after release follows rr_ptr=0.

Structure
REQ-025 Shared package holds NREQ, W, ID width constant, and the state enum (EMPTY, FULL).
REQ-026 Conversion is one combinational sub-module, gray_bin_w (W-bit Gray-to-binary), instanced once on the muxed granted code; the round-robin select and output register live in the top.

Verification
REQ-027 Reset then req=0001, gray_in[0]=1000, out_ready=1 -> gnt=0001 in cycle 0; out_valid=1, out_bin=1111, out_id=0 in cycle 1; rr_ptr=1.
REQ-028 req=1111, codes 0000/0001/0110/1100 on ids 0..3, out_ready=1 -> grants 0,1,2,3 on consecutive cycles; out_bin 0000,0001,0100,1000 in order.
REQ-029 FULL (out_bin=0100, out_id=2), out_ready=0 for 3 cycles with req=1000 -> gnt=0, output stable; out_ready=1 -> same-cycle drain and grant id 3, next out_bin=1000.
REQ-030 rr_ptr=3, req=0101 -> gnt=0001 (wrap), rr_ptr becomes 1; next grant with req still 0101 -> gnt=0100.
REQ-031 rst pulsed asynchronously while FULL -> out_valid falls before next clock edge; after release req=0010, gray 0011 -> out_bin=0010, out_id=1.
REQ-032 Exhaustive sweep: all 16 Gray codes on requester 0 -> out_bin equals 0..15 in Gray order 0000,0001,0011,0010,... respectively.

Source files
------------

// File: rtl/gray_conv_arbiter_pkg.sv
// Shared constants and state type for the Gray-conversion arbiter.
package gray_conv_arbiter_pkg;

  localparam int NREQ = 4;
  localparam int W    = 4;
  localparam int ID_W = 2;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/gray_bin_w.sv
// W-bit combinational Gray-to-binary converter.
module gray_bin_w #(
  parameter int W = 4
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  // Each binary bit is the XOR of all Gray bits at or above its position.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    bin = '0;
    for (int i = 0; i < W; i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter feeding one shared Gray-to-binary converter into a
// single-entry output register with valid/ready handshake.
module gray_conv_arbiter #(
  parameter int NREQ = gray_conv_arbiter_pkg::NREQ,
  parameter int W    = gray_conv_arbiter_pkg::W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ*W-1:0] gray_in,
  output logic [NREQ-1:0] gnt,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_bin,
  output logic [1:0]      out_id
);

  import gray_conv_arbiter_pkg::*;

  state_e            state_q;
  state_e            state_d;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   sel_id;
  logic              accept;
  logic              grant;
  logic [W-1:0]      sel_gray;
  logic [W-1:0]      sel_bin;

  assign out_valid = (state_q == FULL);

  // A slot opens when the register is empty or is being drained this cycle.
  assign accept = (state_q == EMPTY) || out_ready;
  // Reset gating keeps gnt quiet while rst is held, even if requests are up.
  assign grant  = accept && (|req) && !rst;

  // Round-robin pick: scan from the highest offset down so the nearest set
  // request at or after rr_ptr overwrites the others; wrap is the 2-bit add.
  always_comb begin
    sel_id = rr_ptr;
    for (int off = NREQ - 1; off >= 0; off--) begin
      if (req[rr_ptr + ID_W'(off)]) begin
        sel_id = rr_ptr + ID_W'(off);
      end
    end
  end

  // One-hot grant pulse for the selected requester.
  always_comb begin
    gnt = '0;
    if (grant) begin
      gnt[sel_id] = 1'b1;
    end
  end

  assign sel_gray = gray_in[int'(sel_id) * W +: W];

  gray_bin_w #(.W(W)) u_conv (
    .gray (sel_gray),
    .bin  (sel_bin)
  );

  // Next state: a grant fills the register, a drain with no request empties it.
  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = grant ? FULL : EMPTY;
    end
  end

  // State, pointer and output register; reset clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q <= EMPTY;
      rr_ptr  <= '0;
      out_bin <= '0;
      out_id  <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        out_bin <= sel_bin;
        out_id  <= sel_id;
        rr_ptr  <= sel_id + ID_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a
// behavioural round-robin / Gray-decode model.
module tb_gray_conv_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*W-1:0] gray_in = '0;
  logic [NREQ-1:0]   gnt;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [W-1:0]      out_bin;
  logic [1:0]        out_id;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int m_full = 0;
  int m_bin  = 0;
  int m_id   = 0;
  int m_rr   = 0;
  int bin_of[1 << W];

  gray_conv_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gray_in   (gray_in),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bin   (out_bin),
    .out_id    (out_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Winner of a round-robin search from m_rr, or -1 if nothing requests.
  function automatic int pick(input logic [NREQ-1:0] r);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(m_rr + k) % NREQ]) return (m_rr + k) % NREQ;
    end
    return -1;
  endfunction

  // One clock cycle: drive, check grant, clock, advance model, check outputs.
  task automatic step(input logic [NREQ-1:0] r, input logic [NREQ*W-1:0] g, input logic rdy);
    int w;
    logic [NREQ-1:0] exp_gnt;
    logic [W-1:0] code;
    @(negedge clk);
    req = r;
    gray_in = g;
    out_ready = rdy;
    #1;
    w = pick(r);
    exp_gnt = '0;
    if ((m_full == 0 || rdy) && w >= 0) exp_gnt[w] = 1'b1;
    check("gnt", 32'(gnt), 32'(exp_gnt));
    @(posedge clk);
    if (m_full == 0 || rdy) begin
      if (w >= 0) begin
        code   = g[w*W +: W];
        m_bin  = bin_of[code];
        m_id   = w;
        m_rr   = (w + 1) % NREQ;
        m_full = 1;
      end else begin
        m_full = 0;
      end
    end
    #1;
    check("out_valid", 32'(out_valid), 32'(m_full));
    if (m_full != 0) begin
      check("out_bin", 32'(out_bin), 32'(m_bin));
      check("out_id", 32'(out_id), 32'(m_id));
    end
  endtask

  task automatic model_reset();
    m_full = 0;
    m_bin  = 0;
    m_id   = 0;
    m_rr   = 0;
  endtask

  initial begin
    logic [NREQ*W-1:0] g;
    // Binary value b has Gray code b ^ (b >> 1); invert that table.
    for (int b = 0; b < (1 << W); b++) bin_of[b ^ (b >> 1)] = b;

    // Reset state with all requests up
    req = 4'b1111;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_bin", 32'(out_bin), 32'd0);
    check("rst_id", 32'(out_id), 32'd0);
    rst = 1'b0;
    model_reset();

    // Single request, gray 1000 -> 1111
    step(4'b0001, 16'h0008, 1'b1);
    check("single_bin", 32'(out_bin), 32'hF);

    // Four requesters, codes 0000/0001/0110/1100 on ids 0..3
    g = {4'b1100, 4'b0110, 4'b0001, 4'b0000};
    repeat (4) step(4'b1111, g, 1'b1);
    step(4'b0000, g, 1'b1);

    // Fill with id 2 then stall with requester 3 waiting
    step(4'b0100, g, 1'b1);
    repeat (3) step(4'b1000, g, 1'b0);
    step(4'b1000, g, 1'b1);
    check("drain_bin", 32'(out_bin), 32'h8);

    // Pointer at 3, wrap to 0 then 2
    step(4'b0100, g, 1'b1);
    step(4'b0101, g, 1'b1);
    check("wrap_id", 32'(out_id), 32'd0);
    step(4'b0101, g, 1'b1);
    check("wrap_id2", 32'(out_id), 32'd2);

    // Asynchronous reset while holding a result
    step(4'b0010, g, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_valid", 32'(out_valid), 32'd0);
    check("async_bin", 32'(out_bin), 32'd0);
    check("async_gnt", 32'(gnt), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(4'b0010, 16'h0030, 1'b1);
    check("post_rst_bin", 32'(out_bin), 32'h2);

    // All 16 Gray codes on requester 0
    for (int b = 0; b < 16; b++) begin
      g = '0;
      g[3:0] = 4'(b ^ (b >> 1));
      step(4'b0001, g, 1'b1);
      check("sweep", 32'(out_bin), 32'(b));
    end

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      step(4'($urandom_range(0, 15)), 16'($urandom), ($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
